// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-2 valid/ready demultiplexer.
// Incoming beats are steered in bursts of BURST beats to one of two
// output register stages. The route comes from sel (mode=0) or from
// strict alternation (mode=1). Each route has its own output register,
// so a stalled consumer never blocks the other route from draining.
module stream_demux #(
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             sel,
    input  logic             mode,
    output logic [WIDTH-1:0] dout_0,
    output logic [WIDTH-1:0] dout_1,
    output logic             dout_0_valid,
    output logic             dout_1_valid,
    input  logic             dout_0_ready,
    input  logic             dout_1_ready,
    output logic             active,
    output logic [7:0]       beat_cnt
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // Count value held while the final beat of a burst is being accepted.
    localparam logic [7:0] LAST_CNT = 8'(BURST - 1);

    state_t           state_q, state_d;
    logic             active_q, active_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             alt_q, alt_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] data0_q, data0_d;
    logic [WIDTH-1:0] data1_q, data1_d;
    logic             valid0_q, valid0_d;
    logic             valid1_q, valid1_d;

    logic             route_s;
    logic             ready_s;
    logic             accept_s;

    // Effective route: a fresh decision in IDLE, the locked route during a burst.
    always_comb begin
        route_s = active_q;
        if (state_q == ST_IDLE) begin
            route_s = mode ? alt_q : sel;
        end else begin
            route_s = active_q;
        end
    end

    // Input can be taken when the target register is empty or draining this cycle.
    always_comb begin
        ready_s = 1'b0;
        if (route_s) begin
            ready_s = !valid1_q || dout_1_ready;
        end else begin
            ready_s = !valid0_q || dout_0_ready;
        end
        accept_s = din_valid && ready_s;
    end

    // Output register next-state: drain on handshake, refill on accept into this route.
    always_comb begin
        valid0_d = valid0_q && !dout_0_ready;
        data0_d  = data0_q;
        valid1_d = valid1_q && !dout_1_ready;
        data1_d  = data1_q;
        if (accept_s && !route_s) begin
            valid0_d = 1'b1;
            data0_d  = din;
        end else if (accept_s && route_s) begin
            valid1_d = 1'b1;
            data1_d  = din;
        end else begin
            valid0_d = valid0_q && !dout_0_ready;
            valid1_d = valid1_q && !dout_1_ready;
        end
    end

    // Burst FSM: lock the route on the first beat, count beats, release after BURST.
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        alt_d    = alt_q;
        mode_d   = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    active_d = route_s;
                    mode_d   = mode;
                    if (BURST == 1) begin
                        // Single-beat bursts complete immediately.
                        cnt_d = 8'd0;
                        if (mode) begin
                            alt_d = ~route_s;
                        end else begin
                            alt_d = alt_q;
                        end
                    end else begin
                        cnt_d   = 8'd1;
                        state_d = ST_BURST;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (accept_s) begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_IDLE;
                        cnt_d   = 8'd0;
                        // Alternation uses the mode captured when the burst started.
                        if (mode_q) begin
                            alt_d = ~active_q;
                        end else begin
                            alt_d = alt_q;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    state_d = ST_BURST;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            active_q <= 1'b0;
            cnt_q    <= 8'd0;
            alt_q    <= 1'b0;
            mode_q   <= 1'b0;
            data0_q  <= {WIDTH{1'b0}};
            data1_q  <= {WIDTH{1'b0}};
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            alt_q    <= alt_d;
            mode_q   <= mode_d;
            data0_q  <= data0_d;
            data1_q  <= data1_d;
            valid0_q <= valid0_d;
            valid1_q <= valid1_d;
        end
    end

    assign din_ready    = ready_s;
    assign dout_0       = data0_q;
    assign dout_1       = data1_q;
    assign dout_0_valid = valid0_q;
    assign dout_1_valid = valid1_q;
    assign active       = active_q;
    assign beat_cnt     = cnt_q;

endmodule

// File: tb/tb_stream_demux.sv
// Testbench for stream_demux: three instances (BURST = 4, 2, 1) share the
// input stimulus; a behavioural model predicts every output each cycle,
// a vector table covers the sel-directed scenario, and short hand-written
// sequences cover alternation, backpressure, drain/fill, BURST=1 and reset.
module tb_stream_demux;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       din_valid, sel, mode, rdy0, rdy1;

    logic       d_ready [3];
    logic [7:0] d0 [3];
    logic [7:0] d1 [3];
    logic       v0 [3];
    logic       v1 [3];
    logic       act [3];
    logic [7:0] bc [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        stream_demux #(.WIDTH(8), .BURST(g == 0 ? 4 : (g == 1 ? 2 : 1))) u_dut (
            .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(d_ready[g]),
            .sel(sel), .mode(mode), .dout_0(d0[g]), .dout_1(d1[g]),
            .dout_0_valid(v0[g]), .dout_1_valid(v1[g]),
            .dout_0_ready(rdy0), .dout_1_ready(rdy1), .active(act[g]), .beat_cnt(bc[g])
        );
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (per instance)
    int         bursts [3] = '{4, 2, 1};
    bit         m_v [3][2];
    logic [7:0] m_d [3][2];
    int         m_left [3];   // beats still owed to the locked route; 0 = free to choose
    bit         m_act [3];
    int         m_cnt [3];
    bit         m_alt [3];
    bit         m_ml [3];
    bit         seen_rdy [3];

    task automatic chk(input string nm, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, actual, expected);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_v[i][0] = 1'b0; m_v[i][1] = 1'b0;
            m_d[i][0] = 8'h00; m_d[i][1] = 8'h00;
            m_left[i] = 0; m_act[i] = 1'b0; m_cnt[i] = 0;
            m_alt[i] = 1'b0; m_ml[i] = 1'b0;
        end
    endtask

    task automatic set_in(input bit v, input logic [7:0] d, input bit s, input bit m,
                          input bit r0, input bit r1);
        din_valid = v; din = d; sel = s; mode = m; rdy0 = r0; rdy1 = r1;
    endtask

    // One clock: check din_ready before the edge, advance model, check registers after.
    task automatic cycle();
        bit r, rd, take;
        #1;
        for (int i = 0; i < 3; i++) begin
            r  = (m_left[i] != 0) ? m_act[i] : (mode ? m_alt[i] : sel);
            rd = !m_v[i][r] || (r ? rdy1 : rdy0);
            chk($sformatf("din_ready[%0d]", i), int'(d_ready[i]), int'(rd));
            seen_rdy[i] = d_ready[i];
            take = din_valid && rd;
            if (rst) begin
                continue;
            end
            if (rdy0) m_v[i][0] = 1'b0;
            if (rdy1) m_v[i][1] = 1'b0;
            if (take) begin
                m_v[i][r] = 1'b1;
                m_d[i][r] = din;
                if (m_left[i] == 0) begin
                    m_act[i]  = r;
                    m_ml[i]   = mode;
                    m_left[i] = bursts[i];
                end
                m_left[i]--;
                m_cnt[i] = bursts[i] - m_left[i];
                if (m_left[i] == 0) begin
                    m_cnt[i] = 0;
                    if (m_ml[i]) m_alt[i] = ~m_act[i];
                end
            end
        end
        if (rst) model_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("v0[%0d]", i), int'(v0[i]), int'(m_v[i][0]));
            chk($sformatf("v1[%0d]", i), int'(v1[i]), int'(m_v[i][1]));
            chk($sformatf("d0[%0d]", i), int'(d0[i]), int'(m_d[i][0]));
            chk($sformatf("d1[%0d]", i), int'(d1[i]), int'(m_d[i][1]));
            chk($sformatf("active[%0d]", i), int'(act[i]), int'(m_act[i]));
            chk($sformatf("beat_cnt[%0d]", i), int'(bc[i]), m_cnt[i]);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    typedef struct {
        bit v; logic [7:0] d; bit s; bit r0; bit r1;
        bit e_rdy; bit e_v0; logic [7:0] e_d0; bit e_v1; logic [7:0] e_d1;
        logic [7:0] e_cnt; bit e_act;
    } vec_t;

    vec_t tbl [9];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] exp0 [4];
    logic [7:0] exp1 [4];
    bit sp [4];

    initial begin
        // Initial reset without pre-edge checks (outputs are unknown before it).
        rst = 1'b1;
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_v0[%0d]", i), int'(v0[i]), 0);
            chk($sformatf("rst_v1[%0d]", i), int'(v1[i]), 0);
            chk($sformatf("rst_cnt[%0d]", i), int'(bc[i]), 0);
            chk($sformatf("rst_ready[%0d]", i), int'(d_ready[i]), 1);
        end

        // Sel-directed, BURST=4 (instance 0), sel toggling mid-burst ignored.
        tbl[0] = '{1'b1, 8'h10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h10, 8'd1, 1'b1};
        tbl[1] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h11, 8'd2, 1'b1};
        tbl[2] = '{1'b1, 8'h12, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h12, 8'd3, 1'b1};
        tbl[3] = '{1'b1, 8'h13, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h13, 8'd0, 1'b1};
        tbl[4] = '{1'b1, 8'h14, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h14, 1'b0, 8'h13, 8'd1, 1'b0};
        tbl[5] = '{1'b1, 8'h15, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h15, 1'b0, 8'h13, 8'd2, 1'b0};
        tbl[6] = '{1'b1, 8'h16, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h16, 1'b0, 8'h13, 8'd3, 1'b0};
        tbl[7] = '{1'b1, 8'h17, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h17, 1'b0, 8'h13, 8'd0, 1'b0};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h17, 1'b0, 8'h13, 8'd0, 1'b0};
        for (int k = 0; k < 9; k++) begin
            set_in(tbl[k].v, tbl[k].d, tbl[k].s, 1'b0, tbl[k].r0, tbl[k].r1);
            cycle();
            chk($sformatf("tbl%0d_rdy", k), int'(seen_rdy[0]), int'(tbl[k].e_rdy));
            chk($sformatf("tbl%0d_v0", k), int'(v0[0]), int'(tbl[k].e_v0));
            chk($sformatf("tbl%0d_d0", k), int'(d0[0]), int'(tbl[k].e_d0));
            chk($sformatf("tbl%0d_v1", k), int'(v1[0]), int'(tbl[k].e_v1));
            chk($sformatf("tbl%0d_d1", k), int'(d1[0]), int'(tbl[k].e_d1));
            chk($sformatf("tbl%0d_cnt", k), int'(bc[0]), int'(tbl[k].e_cnt));
            chk($sformatf("tbl%0d_act", k), int'(act[0]), int'(tbl[k].e_act));
        end

        // Alternating, BURST=2 (instance 1): A0,A1,A4,A5 -> route 0; A2,A3,A6,A7 -> route 1.
        do_reset();
        exp0 = '{8'hA0, 8'hA1, 8'hA4, 8'hA5};
        exp1 = '{8'hA2, 8'hA3, 8'hA6, 8'hA7};
        for (int k = 0; k < 10; k++) begin
            set_in(k < 8, 8'hA0 + 8'(k), 1'b0, 1'b1, 1'b1, 1'b1);
            cycle();
            if (v0[1] === 1'b1) q0.push_back(d0[1]);
            if (v1[1] === 1'b1) q1.push_back(d1[1]);
        end
        chk("alt_q0_size", q0.size(), 4);
        chk("alt_q1_size", q1.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < q0.size()) chk($sformatf("alt_r0_%0d", k), int'(q0[k]), int'(exp0[k]));
            if (k < q1.size()) chk($sformatf("alt_r1_%0d", k), int'(q1[k]), int'(exp1[k]));
        end

        // Backpressure on BURST=1 instance: beat held on route 1, route 0 stalls 3 cycles.
        do_reset();
        set_in(1'b1, 8'hB1, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle();
        set_in(1'b1, 8'hB2, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        for (int k = 0; k < 3; k++) begin
            set_in(1'b1, 8'hB3, 1'b0, 1'b0, 1'b0, k >= 1);
            cycle();
            chk($sformatf("bp_rdy%0d", k), int'(seen_rdy[2]), 0);
            chk($sformatf("bp_v0_%0d", k), int'(v0[2]), 1);
            chk($sformatf("bp_d0_%0d", k), int'(d0[2]), 8'hB2);
            chk($sformatf("bp_v1_%0d", k), int'(v1[2]), int'(k == 0));
        end
        set_in(1'b1, 8'hB3, 1'b0, 1'b0, 1'b1, 1'b1);
        cycle();
        chk("bp_release_rdy", int'(seen_rdy[2]), 1);
        chk("bp_release_d0", int'(d0[2]), 8'hB3);
        chk("bp_release_v0", int'(v0[2]), 1);

        // Simultaneous drain/fill on route 0 of the BURST=4 instance.
        do_reset();
        for (int k = 0; k < 12; k++) begin
            set_in(1'b1, 8'h40 + 8'(k), 1'b0, 1'b0, 1'b1, 1'b0);
            cycle();
            chk($sformatf("df_rdy%0d", k), int'(seen_rdy[0]), 1);
            chk($sformatf("df_v0_%0d", k), int'(v0[0]), 1);
            chk($sformatf("df_d0_%0d", k), int'(d0[0]), 8'h40 + k);
        end

        // BURST=1, sel pattern 0,1,1,0.
        do_reset();
        sp = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            set_in(1'b1, 8'hC0 + 8'(k), sp[k], 1'b0, 1'b1, 1'b1);
            cycle();
            chk($sformatf("b1_v0_%0d", k), int'(v0[2]), int'(!sp[k]));
            chk($sformatf("b1_v1_%0d", k), int'(v1[2]), int'(sp[k]));
            chk($sformatf("b1_data_%0d", k), int'(sp[k] ? d1[2] : d0[2]), 8'hC0 + k);
            chk($sformatf("b1_cnt_%0d", k), int'(bc[2]), 0);
        end

        // Randomized traffic against the model, with occasional resets.
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(0, 59) == 0);
            set_in($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom), 1'($urandom),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
            cycle();
        end
        rst = 1'b0;

        // Reset mid-traffic: two reset cycles with traffic present.
        for (int k = 0; k < 6; k++) begin
            set_in(1'b1, 8'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0);
            cycle();
        end
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("mrst_v0[%0d]", i), int'(v0[i]), 0);
            chk($sformatf("mrst_v1[%0d]", i), int'(v1[i]), 0);
            chk($sformatf("mrst_d0[%0d]", i), int'(d0[i]), 0);
            chk($sformatf("mrst_d1[%0d]", i), int'(d1[i]), 0);
            chk($sformatf("mrst_cnt[%0d]", i), int'(bc[i]), 0);
            chk($sformatf("mrst_act[%0d]", i), int'(act[i]), 0);
            chk($sformatf("mrst_rdy[%0d]", i), int'(d_ready[i]), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
